counter_window_controller: RTL and testbench
============================================

// Module: counter_window_controller
// PURPOSE
// Sequences the ADPLL UpDownCounter over fixed-length measurement windows.
// - Converts phase-detector up/down pulses into count_instr codes.
// - At each window end, waits for the counter to settle, captures its value, then clears it.
// - Presents each captured phase-error sample to the loop filter with a valid/ready handshake.
// PARAMETERS
// WIDTH   20  counter/sample width; matches UpDownCounter WIDTH (signed)
// LEN_W   16  width of window_len_i (window length in fpga_clk_i cycles)
// PORTS
// fpga_clk_i      in   1      system clock; all logic on rising edge
// reset_i         in   1      synchronous, active-high reset
// enable_i        in   1      1 = run windows; 0 = finish current window, then idle
// window_len_i    in   LEN_W  count cycles per window; sampled at window start
// up_i            in   1      phase detector: one up step this cycle
// down_i          in   1      phase detector: one down step this cycle
// counter_val_i   in   WIDTH  signed value from UpDownCounter counter_val_o
// count_instr_o   out  2      to UpDownCounter: 00 hold, 01 up, 10 down (11 never driven)
// clear_o         out  1      to UpDownCounter clear_i; one-cycle pulse
// sample_o        out  WIDTH  signed captured window value
// sample_valid_o  out  1      sample_o valid; held until accepted
// sample_ready_i  in   1      loop filter accepts sample when valid && ready
// saturated_o     out  1      sticky: a step was suppressed at the counter limit this window
// overrun_o       out  1      sticky: a new sample overwrote an unaccepted one
// BEHAVIOUR
// - Reset (reset_i high at an edge): state IDLE, count_instr_o=00, clear_o=0, sample_o=0,
//   sample_valid_o=0, saturated_o=0, overrun_o=0, window counter=0. Reset mid-window aborts the
//   window; no capture.
// - FSM: IDLE -> CLEAR -> COUNT -> SETTLE -> CAPTURE -> CLEAR -> COUNT ...
// - IDLE: count_instr=00. When enable_i=1, go to CLEAR.
// - CLEAR: clear_o=1 and count_instr=00 for exactly 1 cycle.
//   - Latch window_len_i; a value of 0 is treated as 1.
//   - Clear saturated_o.
//   - Go to COUNT, or to IDLE if enable_i=0.
// - COUNT: lasts exactly len cycles. count_instr_o is combinational from up_i/down_i this cycle:
//   - up only -> 01; down only -> 10; both or neither -> 00.
//   - If counter_val_i == max signed and up is requested, or == min signed and down is
//     requested: drive 00 and set saturated_o.
// - SETTLE: 1 cycle, count_instr=00. Covers the counter's 1-cycle registered output latency;
//   up/down pulses in this cycle are dropped.
// - CAPTURE: 1 cycle.
//   - sample_o <= counter_val_i; sample_valid_o <= 1.
//   - If sample_valid_o was already 1 and not accepted in this same cycle, set overrun_o.
//   - Go to CLEAR.
// - Handshake: sample_valid_o falls on the cycle after valid&&ready, unless CAPTURE reloads
//   in that same cycle (then it stays 1 with the new data).
// - Window period = len + 3 cycles (COUNT + SETTLE + CAPTURE + CLEAR); first window has an
//   extra leading CLEAR.
// - overrun_o clears only on reset. enable_i is ignored except in IDLE and CLEAR.
// STRUCTURE
// - Shared package adpll_pkg: count_instr_t enum (HOLD=2'b00, UP=2'b01, DOWN=2'b10) and state
//   enum {IDLE, CLEAR, COUNT, SETTLE, CAPTURE}. UpDownCounter shares the enum.
// - Single module; window down-counter inline. No sub-module.
// TESTING (bench instantiates UpDownCounter WIDTH=20 alongside)
// - Reset: reset_i=1 for 4 clks -> all outputs 0, count_instr_o=00, state IDLE.
// - Basic window: enable=1, len=8, up_i=1 for all 8 COUNT cycles
//   -> sample_o=8, sample_valid_o=1; clear_o pulse follows.
// - Mixed/simultaneous: len=6 with up,up,down,both,none,up -> codes 01,01,10,00,00,01;
//   sample_o=2.
// - Saturation (WIDTH=4 variant): counter at +7, up_i=1 -> count_instr_o=00, saturated_o=1,
//   sample_o=7.
// - Handshake/overrun: hold sample_ready_i=0 across two windows -> overrun_o=1, sample_o=latest.
//   Then ready=1 -> valid drops the next cycle.
// - len=0 and reset mid-COUNT: len=0 acts as 1 (period 4 cycles). Reset during COUNT
//   -> no sample_valid_o, returns to IDLE.

Source files
------------

// File: rtl/adpll_pkg.sv
// Shared ADPLL types: counter instruction codes and window-controller states.
package adpll_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'b00,
        UP   = 2'b01,
        DOWN = 2'b10
    } count_instr_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        COUNT,
        SETTLE,
        CAPTURE
    } state_t;

endpackage

// File: rtl/counter_window_controller.sv
// Sequences the UpDownCounter over fixed-length windows and hands each
// captured phase-error sample to the loop filter over valid/ready.
module counter_window_controller
    import adpll_pkg::*;
#(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned LEN_W = 16
) (
    input  logic                    fpga_clk_i,
    input  logic                    reset_i,
    input  logic                    enable_i,
    input  logic [LEN_W-1:0]        window_len_i,
    input  logic                    up_i,
    input  logic                    down_i,
    input  logic signed [WIDTH-1:0] counter_val_i,
    output count_instr_t            count_instr_o,
    output logic                    clear_o,
    output logic signed [WIDTH-1:0] sample_o,
    output logic                    sample_valid_o,
    input  logic                    sample_ready_i,
    output logic                    saturated_o,
    output logic                    overrun_o
);

    localparam logic signed [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state;
    state_t             state_next;
    logic [LEN_W-1:0]   win_cnt;
    logic               sat_hit_c;

    // State register
    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and counter instruction (instruction is same-cycle from up/down)
    always_comb begin
        state_next    = state;
        count_instr_o = HOLD;
        sat_hit_c     = 1'b0;
        case (state)
            IDLE: begin
                if (enable_i) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                state_next = enable_i ? COUNT : IDLE;
            end
            COUNT: begin
                if (up_i && !down_i) begin
                    if (counter_val_i == MAX_VAL) begin
                        sat_hit_c = 1'b1;
                    end else begin
                        count_instr_o = UP;
                    end
                end else if (down_i && !up_i) begin
                    if (counter_val_i == MIN_VAL) begin
                        sat_hit_c = 1'b1;
                    end else begin
                        count_instr_o = DOWN;
                    end
                end
                if (win_cnt == LEN_W'(1)) begin
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                state_next = CAPTURE;
            end
            CAPTURE: begin
                state_next = CLEAR;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Window length counter, clear pulse, sticky flags and sample handshake
    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            win_cnt        <= '0;
            clear_o        <= 1'b0;
            sample_o       <= '0;
            sample_valid_o <= 1'b0;
            saturated_o    <= 1'b0;
            overrun_o      <= 1'b0;
        end else begin
            clear_o <= (state_next == CLEAR);

            if (state == CLEAR) begin
                win_cnt <= (window_len_i == '0) ? LEN_W'(1) : window_len_i;
            end else if (state == COUNT) begin
                win_cnt <= win_cnt - LEN_W'(1);
            end

            if (state == CLEAR) begin
                saturated_o <= 1'b0;
            end else if (sat_hit_c) begin
                saturated_o <= 1'b1;
            end

            // A capture reloads the slot even if the old sample is accepted this cycle
            if (state == CAPTURE) begin
                sample_o       <= counter_val_i;
                sample_valid_o <= 1'b1;
                if (sample_valid_o && !sample_ready_i) begin
                    overrun_o <= 1'b1;
                end
            end else if (sample_valid_o && sample_ready_i) begin
                sample_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_counter_window_controller.sv
// Bench for counter_window_controller: two instances (WIDTH=20 and WIDTH=4),
// each paired with a behavioural UpDownCounter, scoreboard on accepted samples.
module tb_counter_window_controller;
    import adpll_pkg::*;

    logic               clk;
    logic               reset;
    logic               en_a;
    logic               en_b;
    logic [15:0]        window_len;
    logic               up;
    logic               down;
    logic               ready;

    logic signed [19:0] cnt_a;
    count_instr_t       instr_a;
    logic               clear_a;
    logic signed [19:0] sample_a;
    logic               valid_a;
    logic               sat_a;
    logic               ovr_a;

    logic signed [3:0]  cnt_b;
    count_instr_t       instr_b;
    logic               clear_b;
    logic signed [3:0]  sample_b;
    logic               valid_b;
    logic               sat_b;
    logic               ovr_b;

    int tests = 0;
    int fails = 0;
    int qa[$];
    int qb[$];

    counter_window_controller #(.WIDTH(20), .LEN_W(16)) dut_a (
        .fpga_clk_i     (clk),
        .reset_i        (reset),
        .enable_i       (en_a),
        .window_len_i   (window_len),
        .up_i           (up),
        .down_i         (down),
        .counter_val_i  (cnt_a),
        .count_instr_o  (instr_a),
        .clear_o        (clear_a),
        .sample_o       (sample_a),
        .sample_valid_o (valid_a),
        .sample_ready_i (ready),
        .saturated_o    (sat_a),
        .overrun_o      (ovr_a)
    );

    counter_window_controller #(.WIDTH(4), .LEN_W(16)) dut_b (
        .fpga_clk_i     (clk),
        .reset_i        (reset),
        .enable_i       (en_b),
        .window_len_i   (window_len),
        .up_i           (up),
        .down_i         (down),
        .counter_val_i  (cnt_b),
        .count_instr_o  (instr_b),
        .clear_o        (clear_b),
        .sample_o       (sample_b),
        .sample_valid_o (valid_b),
        .sample_ready_i (ready),
        .saturated_o    (sat_b),
        .overrun_o      (ovr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural UpDownCounter models (registered output, wraps freely)
    always_ff @(posedge clk) begin
        if (reset || clear_a) begin
            cnt_a <= '0;
        end else if (instr_a == UP) begin
            cnt_a <= cnt_a + 20'sd1;
        end else if (instr_a == DOWN) begin
            cnt_a <= cnt_a - 20'sd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear_b) begin
            cnt_b <= '0;
        end else if (instr_b == UP) begin
            cnt_b <= cnt_b + 4'sd1;
        end else if (instr_b == DOWN) begin
            cnt_b <= cnt_b - 4'sd1;
        end
    end

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int cur_instr(input bit w);
        return w ? int'(instr_b) : int'(instr_a);
    endfunction

    function automatic int cur_sample(input bit w);
        return w ? int'(sample_b) : int'(sample_a);
    endfunction

    // Scoreboard monitor: compares each sample as the loop filter accepts it
    always @(negedge clk) begin
        if (!reset && valid_a && ready) begin
            if (qa.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL mon_a_unexpected: accepted sample %0d, none expected", sample_a);
            end else begin
                check("mon_a_sample", int'(sample_a), qa.pop_front());
            end
        end
        if (!reset && valid_b && ready) begin
            if (qb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL mon_b_unexpected: accepted sample %0d, none expected", sample_b);
            end else begin
                check("mon_b_sample", int'(sample_b), qb.pop_front());
            end
        end
    end

    // One full window, entered and left in the CLEAR state
    task automatic run_window(input bit w, input int len_v, input int n,
                              input logic [15:0] up_p, input logic [15:0] dn_p,
                              input logic [31:0] codes, input bit rdy, input bit push,
                              input int exp_s, input bit exp_sat);
        window_len = 16'(len_v);
        if (w) en_b = 1'b1; else en_a = 1'b1;
        tick();
        ready = rdy;
        if (push) begin
            if (w) qb.push_back(exp_s); else qa.push_back(exp_s);
        end
        for (int i = 0; i < n; i++) begin
            up   = up_p[i];
            down = dn_p[i];
            #1;
            check("count_instr", cur_instr(w), int'(codes[2*i +: 2]));
            tick();
        end
        up   = 1'b1;
        down = 1'b0;
        #1;
        check("settle_hold", cur_instr(w), 0);
        check("settle_no_clear", w ? int'(clear_b) : int'(clear_a), 0);
        tick();
        check("capture_hold", cur_instr(w), 0);
        tick();
        up = 1'b0;
        check("clear_pulse", w ? int'(clear_b) : int'(clear_a), 1);
        check("valid_after_capture", w ? int'(valid_b) : int'(valid_a), 1);
        check("sample_value", cur_sample(w), exp_s);
        check("saturated_flag", w ? int'(sat_b) : int'(sat_a), int'(exp_sat));
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        reset      = 1'b1;
        en_a       = 1'b0;
        en_b       = 1'b0;
        window_len = '0;
        up         = 1'b1;
        down       = 1'b0;
        ready      = 1'b1;

        // Reset state
        repeat (4) tick();
        check("rst_instr", int'(instr_a), 0);
        check("rst_clear", int'(clear_a), 0);
        check("rst_sample", int'(sample_a), 0);
        check("rst_valid", int'(valid_a), 0);
        check("rst_sat", int'(sat_a), 0);
        check("rst_ovr", int'(ovr_a), 0);
        reset = 1'b0;
        up    = 1'b0;
        tick();
        check("idle_no_clear", int'(clear_a), 0);

        // Basic window, then mixed/simultaneous steps
        en_a = 1'b1;
        tick();
        check("leading_clear", int'(clear_a), 1);
        run_window(1'b0, 8, 8, 16'h00FF, 16'h0000, 32'h0000_5555, 1'b1, 1'b1, 8, 1'b0);
        run_window(1'b0, 6, 6, 16'h002B, 16'h000C, 32'h0000_0425, 1'b1, 1'b1, 2, 1'b0);

        // Overrun: two windows with ready held low, only the latest sample survives
        run_window(1'b0, 3, 3, 16'h0007, 16'h0000, 32'h0000_0015, 1'b0, 1'b0, 3, 1'b0);
        check("no_overrun_first", int'(ovr_a), 0);
        run_window(1'b0, 2, 2, 16'h0000, 16'h0003, 32'h0000_000A, 1'b0, 1'b1, -2, 1'b0);
        check("overrun_set", int'(ovr_a), 1);
        en_a  = 1'b0;
        ready = 1'b1;
        tick();
        check("valid_drops", int'(valid_a), 0);
        check("overrun_sticky", int'(ovr_a), 1);
        check("idle_after_disable", int'(clear_a), 0);

        // Zero length behaves as one-cycle windows
        en_a = 1'b1;
        tick();
        check("leading_clear_2", int'(clear_a), 1);
        run_window(1'b0, 0, 1, 16'h0001, 16'h0000, 32'h0000_0001, 1'b1, 1'b1, 1, 1'b0);
        run_window(1'b0, 0, 1, 16'h0000, 16'h0001, 32'h0000_0002, 1'b1, 1'b1, -1, 1'b0);

        // Reset during COUNT aborts the window
        window_len = 16'd10;
        up = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b1;
        en_a  = 1'b0;
        tick();
        reset = 1'b0;
        check("midrst_valid", int'(valid_a), 0);
        check("midrst_sample", int'(sample_a), 0);
        check("midrst_ovr", int'(ovr_a), 0);
        check("midrst_instr", int'(instr_a), 0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (clear_a || valid_a) seen++;
        end
        check("midrst_stays_idle", seen, 0);
        up = 1'b0;

        // Saturation on the 4-bit instance, at both limits
        en_b = 1'b1;
        tick();
        check("b_leading_clear", int'(clear_b), 1);
        run_window(1'b1, 10, 10, 16'h03FF, 16'h0000, 32'h0000_1555, 1'b1, 1'b1, 7, 1'b1);
        run_window(1'b1, 10, 10, 16'h0000, 16'h03FF, 32'h0000_AAAA, 1'b1, 1'b1, -8, 1'b1);
        en_b = 1'b0;
        tick();
        check("b_sat_cleared", int'(sat_b), 0);
        check("b_no_overrun", int'(ovr_b), 0);
        check("b_valid_drops", int'(valid_b), 0);

        tick();
        tick();
        check("queue_a_drained", qa.size(), 0);
        check("queue_b_drained", qb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
